// File: rtl/grid_io_pkg.sv
// grid_io_pkg: shared constants, per-pad config layout and FSM state type for
// the grid IO config array.
// Build option: CCFF_PARITY_EN adds an odd-parity bit per pad field (CFG_BITS=3).
package grid_io_pkg;

`ifdef CCFF_PARITY_EN
  localparam int unsigned CFG_BITS = 3;
`else
  localparam int unsigned CFG_BITS = 2;
`endif

  localparam int unsigned CFG_DIR_IDX = 0;
  localparam int unsigned CFG_INV_IDX = 1;
  localparam int unsigned CFG_PAR_IDX = 2;

  // Safe reset field: pad is an input, no inversion, parity bit 0.
  localparam logic [CFG_BITS-1:0] CFG_RST = CFG_BITS'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/grid_io_pad_cfg.sv
// grid_io_pad_cfg: one pad's direction / polarity / isolation datapath.
// Ports:
//   dir_i, inv_i  active config bits (dir=1 means the pad is an input)
//   isol_n_i      global isolation, active low
//   pad_in_i      value seen on the pad
//   fab_out_i     fabric data driven toward the pad
//   pad_out_o     value driven onto the pad
//   pad_dir_o     effective pad direction (1 = input)
//   fab_in_o      pad data delivered to the fabric
module grid_io_pad_cfg (
  input  logic dir_i,
  input  logic inv_i,
  input  logic isol_n_i,
  input  logic pad_in_i,
  input  logic fab_out_i,
  output logic pad_out_o,
  output logic pad_dir_o,
  output logic fab_in_o
);

  // Isolation parks every pad as a quiet input regardless of config.
  assign pad_dir_o = dir_i | ~isol_n_i;
  assign pad_out_o = isol_n_i & ~dir_i & (fab_out_i ^ inv_i);
  assign fab_in_o  = isol_n_i &  dir_i & (pad_in_i  ^ inv_i);

endmodule

// File: rtl/grid_io_cfg_array.sv
// grid_io_cfg_array: NUM_IO SoC IO pads configured through a ccff scan chain
// with a shadow chain / active config split applied atomically on commit.
// Build option: CCFF_PARITY_EN enables per-pad odd parity checking on commit.
// Ports:
//   prog_clk, prog_reset_n            clock, synchronous active-low reset
//   IO_ISOL_N                         global isolation, active low
//   ccff_head, ccff_en, ccff_tail     serial config chain in / enable / out
//   cfg_commit                        copy the full chain into the active config
//   gfpga_pad_EMBEDDED_IO_HD_SOC_*    pad IN / OUT / DIR (DIR 1 = input)
//   fabric_outpad, fabric_inpad       fabric-side data
//   cfg_done                          chain holds CHAIN_LEN fresh bits
//   commit_ack                        one-cycle pulse after the active config updates
//   cfg_err                           sticky parity error
module grid_io_cfg_array
  import grid_io_pkg::*;
#(
  parameter int unsigned NUM_IO = 9
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              IO_ISOL_N,
  input  logic              ccff_head,
  input  logic              ccff_en,
  input  logic              cfg_commit,
  input  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
  output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
  output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR,
  input  logic [NUM_IO-1:0] fabric_outpad,
  output logic [NUM_IO-1:0] fabric_inpad,
  output logic              ccff_tail,
  output logic              cfg_done,
  output logic              commit_ack,
  output logic              cfg_err
);

  localparam int unsigned CHAIN_LEN = NUM_IO * CFG_BITS;
  localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1);

  cfg_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] chain_q, chain_d;
  logic [NUM_IO-1:0]    dir_q, dir_d;
  logic [NUM_IO-1:0]    inv_q, inv_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic                 par_bad_c;

  // Any pad field with even parity rejects the whole commit.
  always_comb begin
    par_bad_c = 1'b0;
`ifdef CCFF_PARITY_EN
    for (int k = 0; k < int'(NUM_IO); k++) begin
      if (!(^chain_q[k*CFG_BITS +: CFG_BITS])) par_bad_c = 1'b1;
    end
`endif
  end

  // State, counter, chain and active config registers.
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      chain_q <= '0;
      dir_q   <= {NUM_IO{CFG_RST[CFG_DIR_IDX]}};
      inv_q   <= {NUM_IO{CFG_RST[CFG_INV_IDX]}};
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chain_q <= chain_d;
      dir_q   <= dir_d;
      inv_q   <= inv_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Next-state: shift/count, commit in FULL only; commit samples the pre-shift chain.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chain_d = chain_q;
    dir_d   = dir_q;
    inv_d   = inv_q;
    ack_d   = 1'b0;
    err_d   = err_q;

    if (ccff_en) chain_d = {chain_q[CHAIN_LEN-2:0], ccff_head};

    unique case (state_q)
      IDLE: begin
        if (ccff_en) begin
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ccff_en) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(CHAIN_LEN - 1)) state_d = FULL;
        end
      end
      FULL: begin
        if (cfg_commit) begin
          if (ccff_en) begin
            cnt_d   = CNT_W'(1);
            state_d = SHIFT;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
          if (par_bad_c) begin
            err_d = 1'b1;
          end else begin
            ack_d = 1'b1;
            err_d = 1'b0;
            for (int k = 0; k < int'(NUM_IO); k++) begin
              dir_d[k] = chain_q[k*CFG_BITS + CFG_DIR_IDX];
              inv_d[k] = chain_q[k*CFG_BITS + CFG_INV_IDX];
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    done_d = (state_d == FULL);
  end

  assign ccff_tail  = chain_q[CHAIN_LEN-1];
  assign cfg_done   = done_q;
  assign commit_ack = ack_q;
  assign cfg_err    = err_q;

  for (genvar k = 0; k < NUM_IO; k++) begin : g_pad
    grid_io_pad_cfg u_pad (
      .dir_i     (dir_q[k]),
      .inv_i     (inv_q[k]),
      .isol_n_i  (IO_ISOL_N),
      .pad_in_i  (gfpga_pad_EMBEDDED_IO_HD_SOC_IN[k]),
      .fab_out_i (fabric_outpad[k]),
      .pad_out_o (gfpga_pad_EMBEDDED_IO_HD_SOC_OUT[k]),
      .pad_dir_o (gfpga_pad_EMBEDDED_IO_HD_SOC_DIR[k]),
      .fab_in_o  (fabric_inpad[k])
    );
  end

endmodule

// File: tb/tb_grid_io_cfg_array.sv
// tb_grid_io_cfg_array: directed, table-driven check of grid_io_cfg_array.
module tb_grid_io_cfg_array;
  import grid_io_pkg::*;

  localparam int unsigned NIO = 9;
  localparam int unsigned CL  = NIO * CFG_BITS;

  logic           prog_clk;
  logic           prog_reset_n;
  logic           io_isol_n;
  logic           ccff_head;
  logic           ccff_en;
  logic           cfg_commit;
  logic [NIO-1:0] pad_in;
  logic [NIO-1:0] pad_out;
  logic [NIO-1:0] pad_dir;
  logic [NIO-1:0] fab_out;
  logic [NIO-1:0] fab_in;
  logic           ccff_tail;
  logic           cfg_done;
  logic           commit_ack;
  logic           cfg_err;

  int n_chk  = 0;
  int n_fail = 0;

  grid_io_cfg_array #(.NUM_IO(NIO)) dut (
    .prog_clk                         (prog_clk),
    .prog_reset_n                     (prog_reset_n),
    .IO_ISOL_N                        (io_isol_n),
    .ccff_head                        (ccff_head),
    .ccff_en                          (ccff_en),
    .cfg_commit                       (cfg_commit),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_IN  (pad_in),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_OUT (pad_out),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_DIR (pad_dir),
    .fabric_outpad                    (fab_out),
    .fabric_inpad                     (fab_in),
    .ccff_tail                        (ccff_tail),
    .cfg_done                         (cfg_done),
    .commit_ack                       (commit_ack),
    .cfg_err                          (cfg_err)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  typedef struct {
    int             cfg;
    logic           isol_n;
    logic [NIO-1:0] pin;
    logic [NIO-1:0] fab;
    logic [NIO-1:0] e_out;
    logic [NIO-1:0] e_dir;
    logic [NIO-1:0] e_in;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CL-1:0] mk_chain(input logic [NIO-1:0] dir, input logic [NIO-1:0] inv);
    logic [CL-1:0] v;
    v = '0;
    for (int k = 0; k < int'(NIO); k++) begin
      v[k*CFG_BITS + CFG_DIR_IDX] = dir[k];
      v[k*CFG_BITS + CFG_INV_IDX] = inv[k];
`ifdef CCFF_PARITY_EN
      v[k*CFG_BITS + CFG_PAR_IDX] = ~(dir[k] ^ inv[k]);
`endif
    end
    return v;
  endfunction

  task automatic shift_bit(input logic b);
    ccff_en   = 1'b1;
    ccff_head = b;
    @(posedge prog_clk);
    #1;
    ccff_en   = 1'b0;
    ccff_head = 1'b0;
  endtask

  // Highest index goes in first so bit 0 ends nearest ccff_head.
  task automatic shift_range(input logic [CL-1:0] v, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) shift_bit(v[i]);
  endtask

  task automatic do_commit();
    cfg_commit = 1'b1;
    @(posedge prog_clk);
    #1;
    cfg_commit = 1'b0;
  endtask

  task automatic load_cfg(input logic [NIO-1:0] dir, input logic [NIO-1:0] inv);
    shift_range(mk_chain(dir, inv), CL - 1, 0);
    chk("load_done_full", 32'(cfg_done), 32'd1);
    do_commit();
    chk("load_ack_pulse", 32'(commit_ack), 32'd1);
    chk("load_done_clr", 32'(cfg_done), 32'd0);
    @(posedge prog_clk);
    #1;
    chk("load_ack_single", 32'(commit_ack), 32'd0);
  endtask

  initial begin
    logic [CL-1:0] zc;
    logic [CL-1:0] bad;
    int            cur;

    // pad0 output inverted; rest safe inputs
    tbl[0] = '{0, 1'b1, 9'h000, 9'h000, 9'h001, 9'h1FE, 9'h000};
    tbl[1] = '{0, 1'b1, 9'h1FF, 9'h001, 9'h000, 9'h1FE, 9'h1FE};
    tbl[2] = '{0, 1'b1, 9'h0A5, 9'h1FE, 9'h001, 9'h1FE, 9'h0A4};
    tbl[3] = '{0, 1'b0, 9'h1FF, 9'h000, 9'h000, 9'h1FF, 9'h000};
    // pad0 out inv, pad1 in inv, pad2 out plain
    tbl[4] = '{1, 1'b1, 9'h000, 9'h000, 9'h001, 9'h1FA, 9'h002};
    tbl[5] = '{1, 1'b1, 9'h1FF, 9'h1FF, 9'h004, 9'h1FA, 9'h1F8};
    tbl[6] = '{1, 1'b0, 9'h1FF, 9'h1FF, 9'h000, 9'h1FF, 9'h000};

    prog_reset_n = 1'b0;
    io_isol_n    = 1'b1;
    ccff_head    = 1'b0;
    ccff_en      = 1'b0;
    cfg_commit   = 1'b0;
    pad_in       = '0;
    fab_out      = '0;
    repeat (2) @(posedge prog_clk);
    #1;
    prog_reset_n = 1'b1;
    #1;
    chk("rst_dir", 32'(pad_dir), 32'h1FF);
    chk("rst_out", 32'(pad_out), 32'h0);
    chk("rst_inpad", 32'(fab_in), 32'h0);
    chk("rst_done", 32'(cfg_done), 32'd0);
    chk("rst_ack", 32'(commit_ack), 32'd0);
    chk("rst_tail", 32'(ccff_tail), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);

    cur = -1;
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].cfg != cur) begin
        io_isol_n = 1'b1;
        if (tbl[i].cfg == 0) load_cfg(9'h1FE, 9'h001);
        else                 load_cfg(9'h1FA, 9'h003);
        cur = tbl[i].cfg;
      end
      io_isol_n = tbl[i].isol_n;
      pad_in    = tbl[i].pin;
      fab_out   = tbl[i].fab;
      #1;
      chk($sformatf("vec%0d_out", i), 32'(pad_out), 32'(tbl[i].e_out));
      chk($sformatf("vec%0d_dir", i), 32'(pad_dir), 32'(tbl[i].e_dir));
      chk($sformatf("vec%0d_inpad", i), 32'(fab_in), 32'(tbl[i].e_in));
    end
    io_isol_n = 1'b1;
    pad_in    = '0;
    fab_out   = '0;
    #1;

    // Commit before the chain is full is ignored and does not reset the count.
    zc = mk_chain(9'h000, 9'h000);
    shift_range(zc, CL - 1, CL - 10);
    chk("part_done", 32'(cfg_done), 32'd0);
    do_commit();
    chk("part_no_ack", 32'(commit_ack), 32'd0);
    chk("part_dir_kept", 32'(pad_dir), 32'h1FA);
    @(posedge prog_clk);
    #1;
    chk("part_no_ack2", 32'(commit_ack), 32'd0);
    shift_range(zc, CL - 11, 0);
    chk("part_done_full", 32'(cfg_done), 32'd1);

    // Shift and commit together in FULL: pre-shift chain applied, count restarts at 1.
    ccff_en    = 1'b1;
    ccff_head  = 1'b0;
    cfg_commit = 1'b1;
    @(posedge prog_clk);
    #1;
    ccff_en    = 1'b0;
    cfg_commit = 1'b0;
    chk("comb_ack", 32'(commit_ack), 32'd1);
    chk("comb_done", 32'(cfg_done), 32'd0);
    chk("comb_dir", 32'(pad_dir), 32'h000);
    shift_bit(1'b1);
    for (int i = 0; i < int'(CL) - 2; i++) shift_bit(1'b0);
    chk("comb_ack_gone", 32'(commit_ack), 32'd0);
    chk("comb_done_sat", 32'(cfg_done), 32'd1);
    chk("comb_tail_pre", 32'(ccff_tail), 32'd0);
    shift_bit(1'b0);
    chk("comb_tail_first", 32'(ccff_tail), 32'd1);
    shift_bit(1'b0);
    chk("comb_tail_next", 32'(ccff_tail), 32'd0);
    chk("comb_done_pass", 32'(cfg_done), 32'd1);

    // Isolation overrides outputs without touching the active config.
    load_cfg(9'h1FE, 9'h001);
    #1;
    chk("iso_pre_out", 32'(pad_out), 32'h001);
    chk("iso_pre_dir", 32'(pad_dir), 32'h1FE);
    io_isol_n = 1'b0;
    pad_in    = 9'h1FF;
    #1;
    chk("iso_dir", 32'(pad_dir), 32'h1FF);
    chk("iso_out", 32'(pad_out), 32'h000);
    chk("iso_inpad", 32'(fab_in), 32'h000);
    io_isol_n = 1'b1;
    pad_in    = '0;
    #1;
    chk("iso_rel_out", 32'(pad_out), 32'h001);
    chk("iso_rel_dir", 32'(pad_dir), 32'h1FE);

    // Reset mid-shift drops the partial chain and restores safe pads.
    for (int i = 0; i < 5; i++) shift_bit(1'b1);
    prog_reset_n = 1'b0;
    @(posedge prog_clk);
    #1;
    prog_reset_n = 1'b1;
    chk("mrst_tail", 32'(ccff_tail), 32'd0);
    chk("mrst_done", 32'(cfg_done), 32'd0);
    chk("mrst_dir", 32'(pad_dir), 32'h1FF);
    chk("mrst_out", 32'(pad_out), 32'h000);
    for (int i = 0; i < int'(CL); i++) begin
      shift_bit(1'b0);
      chk($sformatf("mrst_tail%0d", i), 32'(ccff_tail), 32'd0);
    end
    chk("mrst_done_full", 32'(cfg_done), 32'd1);

`ifdef CCFF_PARITY_EN
    do_commit();
    chk("par_zero_err", 32'(cfg_err), 32'd1);
    chk("par_zero_no_ack", 32'(commit_ack), 32'd0);
    load_cfg(9'h1FE, 9'h001);
    chk("par_good_err_clr", 32'(cfg_err), 32'd0);
    bad = mk_chain(9'h1FA, 9'h003);
    bad[3*CFG_BITS + CFG_PAR_IDX] = ~bad[3*CFG_BITS + CFG_PAR_IDX];
    shift_range(bad, CL - 1, 0);
    do_commit();
    chk("par_bad_err", 32'(cfg_err), 32'd1);
    chk("par_bad_no_ack", 32'(commit_ack), 32'd0);
    chk("par_bad_dir", 32'(pad_dir), 32'h1FE);
    chk("par_bad_done", 32'(cfg_done), 32'd0);
    load_cfg(9'h1FA, 9'h003);
    chk("par_fix_err", 32'(cfg_err), 32'd0);
    chk("par_fix_dir", 32'(pad_dir), 32'h1FA);
`else
    bad = '0;
    shift_range(bad, 0, 0);
    chk("nopar_err", 32'(cfg_err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
